// File: rtl/calc_pkg.sv
// Shared calculator definitions: ALU opcode constants and the button-sequencer state encoding.
package calc_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1001;
  localparam logic [3:0] OP_NOR = 4'b1010;
  localparam logic [3:0] OP_SLL = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PRESS = 2'd2,
    ST_GAP   = 2'd3
  } enc_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/op_to_buttons.sv
// Combinational inverse of the button decoder: opcode -> {l,c,r} levels plus an encodable flag.
module op_to_buttons
  import calc_pkg::*;
(
  input  logic [3:0] op_i,
  output logic       valid_o,
  output logic [2:0] btn_o
);

  // Opcode lookup; anything outside the eight supported opcodes is flagged invalid
  always_comb begin
    valid_o = 1'b1;
    btn_o   = 3'b000;
    case (op_i)
      OP_AND:  btn_o = 3'b010;
      OP_OR:   btn_o = 3'b011;
      OP_ADD:  btn_o = 3'b000;
      OP_SUB:  btn_o = 3'b001;
      OP_SLT:  btn_o = 3'b101;
      OP_XOR:  btn_o = 3'b110;
      OP_NOR:  btn_o = 3'b111;
      OP_SLL:  btn_o = 3'b100;
      default: begin
        valid_o = 1'b0;
        btn_o   = 3'b000;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_encoder.sv
// Replays a requested ALU opcode as button levels followed by a timed btnd enter pulse.
module alu_op_encoder
  import calc_pkg::*;
#(
  parameter int SETUP_CYC = 4,
  parameter int HOLD_CYC  = 16,
  parameter int GAP_CYC   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [3:0] req_op,
  output logic       req_ready,
  output logic       btnl,
  output logic       btnc,
  output logic       btnr,
  output logic       btnd,
  output logic       done,
  output logic       err
);

  localparam int MAX_CYC = max3(SETUP_CYC, HOLD_CYC, GAP_CYC);
  localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] S_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] H_LOAD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  enc_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       lvl_q;
  logic             btnd_q;
  logic             ready_q;
  logic             done_q;
  logic             err_q;

  logic             map_valid_s;
  logic [2:0]       map_btn_s;

  op_to_buttons u_op_to_buttons (
    .op_i    (req_op),
    .valid_o (map_valid_s),
    .btn_o   (map_btn_s)
  );

  // Sequencer FSM; every output is a register so nothing on the inputs reaches the buttons combinationally
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      lvl_q   <= 3'b000;
      btnd_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid && ready_q) begin
            if (map_valid_s) begin
              lvl_q   <= map_btn_s;
              cnt_q   <= S_LOAD;
              ready_q <= 1'b0;
              state_q <= ST_SETUP;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          if (cnt_q == CNT_ZERO) begin
            cnt_q   <= H_LOAD;
            btnd_q  <= 1'b1;
            state_q <= ST_PRESS;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_PRESS: begin
          if (cnt_q == CNT_ZERO) begin
            cnt_q   <= G_LOAD;
            btnd_q  <= 1'b0;
            state_q <= ST_GAP;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_GAP: begin
          if (cnt_q == CNT_ZERO) begin
            lvl_q   <= 3'b000;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          cnt_q   <= CNT_ZERO;
          lvl_q   <= 3'b000;
          btnd_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign btnl      = lvl_q[2];
  assign btnc      = lvl_q[1];
  assign btnr      = lvl_q[0];
  assign btnd      = btnd_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/alu_op_encoder.md
# alu_op_encoder

Button-sequence driver for the calculator: it accepts a 4-bit ALU opcode over a valid/ready handshake and replays it as the button combination that produces that opcode. It drives btnl/btnc/btnr levels, then pulses the enter button btnd with fixed setup, hold and release timing. It sits in front of the button-to-opcode decoder and feeds the calculator FSM in self-test and demo mode. Decoding its button outputs must always reproduce the requested opcode.

## Interface
- SETUP_CYC, default 4: cycles the btnl/btnc/btnr levels are held before btnd rises (≥1).
- HOLD_CYC, default 16: cycles btnd is held high (≥1).
- GAP_CYC, default 4: cycles the levels are held after btnd falls (≥1).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  a request is presented.
- req_op  in  4  requested ALU opcode.
- req_ready  out  1  high only in IDLE.
- btnl, btnc, btnr  out  1 each  operation-select button levels.
- btnd  out  1  enter/commit button.
- done  out  1  one-cycle pulse when a sequence completes.
- err  out  1  one-cycle pulse when an unencodable opcode is rejected.

## Operation
- Inverse map, opcode → (btnl,btnc,btnr):
  - 0000→010, 0001→011, 0010→000, 0110→001
  - 0111→101, 1001→110, 1010→111, 1101→100
- All other opcodes (3, 4, 5, 8, 11, 12, 14, 15) are invalid.
- FSM states: IDLE, SETUP, PRESS, GAP.
- IDLE: req_ready=1, all buttons 0.
  - On req_valid&req_ready with a valid opcode: register the three levels, load cnt=SETUP_CYC-1, go to SETUP.
  - With an invalid opcode: err=1 next cycle, stay in IDLE, buttons stay 0.
- SETUP: levels driven, btnd=0. At cnt==0: load HOLD_CYC-1, go to PRESS. Otherwise decrement.
- PRESS: levels driven, btnd=1. At cnt==0: load GAP_CYC-1, go to GAP.
- GAP: levels driven, btnd=0. At cnt==0: go to IDLE, clear levels, done=1 for that single cycle.
- req_op is sampled only at acceptance. Changes to it while busy are ignored.
- req_valid while busy is not consumed. It is accepted once req_ready returns.
- Down-counter width is clog2 of max(SETUP_CYC, HOLD_CYC, GAP_CYC), minimum 1 bit. It never wraps, because reload always precedes zero-underflow.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Timing
- Reset: state IDLE; btnl=btnc=btnr=btnd=0; done=0; err=0; req_ready=1 from the first cycle after reset.
- Reset mid-sequence, in any state: at the next edge all outputs are 0 and the state is IDLE. No done or err pulse is generated.
- Accept at edge E0:
  - Levels are valid from E0 through E(S+H+G), exclusive of the latter.
  - btnd is high during cycles E(S)..E(S+H).
  - done, together with the level clear, occurs in the cycle after E(S+H+G).
  - S=SETUP_CYC, H=HOLD_CYC, G=GAP_CYC.
- btnd never rises in the same cycle the levels change, and never falls in the same cycle they clear.
- Back-to-back: req_ready is high in the done cycle, so the earliest next accept is E(S+H+G+1). Sequence period is S+H+G+1 cycles.
- Rejection (err) costs one cycle. The next request can be accepted at the following edge.
- done and err are never high together.

## Structure
- Shared package calc_pkg holds:
  - the eight opcode constants (OP_AND=0000, OP_OR=0001, OP_ADD=0010, OP_SUB=0110, 0111, 1001, 1010, 1101 under their team names)
  - the FSM state enum.
- The decoder and this block both reference the calc_pkg opcode constants.
- Sub-module op_to_buttons: a purely combinational lookup, req_op → {valid, l, c, r}. Unit-test it separately against the decoder for the round-trip property.

## Test plan
- Round trip, defaults: issue all eight valid opcodes. Feeding btnl/btnc/btnr into the decoder while btnd=1 must reproduce each req_op. 8 done pulses, 0 err.
- Cycle timing, S=4/H=16/G=4, req_op=0110, accept at E0: (l,c,r)=001 from E0; btnd high for exactly 16 cycles starting at E4; done single pulse after E24; req_ready low for 24 cycles.
- Invalid opcode 0100: err=1 for one cycle, no button activity, req_ready stays 1. Then opcode 0010 is accepted on the next edge.
- Back-to-back with req_valid held high, opcodes 1101 then 0001: second accept exactly 25 cycles after the first; levels go 100 → 000 (done cycle) → 011.
- Reset asserted during PRESS of opcode 1010: the next cycle has all buttons 0, state IDLE, no done, req_ready=1.
- req_op changed from 0000 to 1001 mid-SETUP: outputs stay at 010 for the whole sequence.
